imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a program as a byte stream over a valid/ready handshake.
- Packs each group of 4 bytes into one 32-bit instruction word and issues one-cycle word writes to the instruction memory write port.
- Word addresses are consecutive, starting at 0, matching the memory's word-indexed read port.
- Holds the CPU in reset (cpu_hold) from power-up until a load completes, then releases it.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in instruction memory.
- ADDR_W, 8, width of the word address and of word_count (matches the PC/address width).
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- word_count  input  ADDR_W  words to load, sampled on start; 0 or values > DEPTH mean DEPTH.
- in_byte  input  8  program byte, most-significant byte of each word first (big-endian).
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  DATA_W  instruction word being written.
- busy  output  1  load in progress (ASSEMBLE or WRITE).
- done  output  1  load complete; stays high until the next accepted start.
- cpu_hold  output  1  active-high hold for the CPU; low only in DONE.
- start_err  output  1  one-cycle pulse when start arrives while busy; that start is ignored.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_hold=1, start_err=0.
  - Byte counter, word counter and pack register clear.
  - Reset mid-load abandons the load with no further writes; memory contents already written are left untouched.
- States: IDLE, ASSEMBLE, WRITE, DONE.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - On start: latch the effective count (0 or >DEPTH becomes DEPTH), clear wr_addr and byte index, go to ASSEMBLE.
- ASSEMBLE:
  - in_ready=1; a byte is accepted when in_valid && in_ready.
  - Byte k (k=0..3) is stored in pack bits [31-8k:24-8k].
  - On the 4th accepted byte, go to WRITE.
  - in_valid low simply stalls, with no timeout.
- WRITE (exactly one cycle):
  - wr_en=1, wr_data=packed word, wr_addr=current word index, in_ready=0.
  - Next cycle: wr_addr increments.
  - If that word was index count-1, go to DONE; otherwise return to ASSEMBLE.
  - wr_addr never exceeds DEPTH-1 while wr_en=1.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - A start restarts the load: done falls and cpu_hold rises the next cycle, then behaviour is as from IDLE.
- Latency and throughput:
  - The 4th byte is accepted in cycle N; wr_en is high in cycle N+1.
  - Best case is 5 cycles per word.
  - For the final word, done and cpu_hold release appear at cycle N+2.
- start during ASSEMBLE/WRITE: ignored, start_err pulses the following cycle, and the load continues unaffected.
- start coincident with the last WRITE cycle: also ignored with start_err.
- wr_addr holds its value when wr_en=0; wr_data holds the last written word.
- All outputs are registered except in_ready, which is decoded from state.

Decomposition:
- Shared package imem_pkg holds:
  - loader state enum (IDLE, ASSEMBLE, WRITE, DONE);
  - IMEM_DEPTH=64, IMEM_ADDR_W=8, INSTR_W=32;
  - BYTES_PER_WORD=4.
- One natural sub-module, imem_byte_packer:
  - 2-bit byte index and 32-bit shift/pack register;
  - inputs: accept, byte, clear;
  - outputs: word, word_full.
  - The FSM, counters, hold and error logic stay in imem_loader.

Test Plan:
- Reset then idle: rst_n low 3 cycles → cpu_hold=1, done=0, in_ready=0, wr_en=0, wr_addr=0, with no writes for 20 cycles.
- Load of 2 words: start with word_count=2, bytes 20,08,00,05,01,09,50,20 with in_valid held high → wr_en at addr0 data 0x20080005, then addr1 data 0x01095020; done=1 and cpu_hold=0 two cycles after the 8th byte; exactly 2 writes.
- Backpressure/gaps: same stream with in_valid toggled randomly → identical write sequence; no byte lost or duplicated; in_ready=0 during each WRITE cycle.
- Count clamp: word_count=0, then a run with word_count=200 → each run writes 64 words, addr 0..63, last write at addr 63, never addr 64.
- Start while busy: start pulse after byte 2 of word 0 → start_err pulses once; load completes with the original count; then start in DONE with word_count=1 restarts from addr0, cpu_hold=1 until that word is written.
- Reset mid-load: rst_n low after byte 3 of word 1 → no wr_en from that cycle on, all outputs at reset values; a fresh load of 1 word (0xDEADBEEF) then writes to addr0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_ADDR_W    = 8;
    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs big-endian bytes into a 32-bit instruction word.
// 'word' shows the pack register with the current byte merged in at its
// slot, so the loader can capture a complete word on the edge that accepts
// the fourth byte.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               accept,
    input  logic [7:0]         data_byte,
    input  logic               clear,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [1:0]         idx;
    logic [INSTR_W-1:0] pack;

    // Merge the incoming byte into its big-endian slot (byte 0 is the MSB).
    always_comb begin
        word = pack;
        case (idx)
            2'd0:    word[31:24] = data_byte;
            2'd1:    word[23:16] = data_byte;
            2'd2:    word[15:8]  = data_byte;
            default: word[7:0]   = data_byte;
        endcase
    end

    assign word_full = accept && (idx == 2'(BYTES_PER_WORD - 1));

    // Byte index and pack register; the index wraps to 0 after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            pack <= '0;
        end else if (clear) begin
            idx  <= 2'd0;
            pack <= '0;
        end else if (accept) begin
            idx  <= idx + 2'd1;
            pack <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, one-cycle word writes out,
// CPU held in reset until a complete program has been written.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | after reset, waiting for start; CPU held
//  ASSEMBLE | accepting bytes into the pack register (in_ready=1)
//  WRITE    | single cycle, wr_en=1 with the packed word at wr_addr
//  DONE     | program loaded, CPU released; start reloads
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              start_err
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    loader_state_t     state, state_d;
    logic [ADDR_W-1:0] count, count_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              wr_en_d, busy_d, done_d, hold_d, err_d;
    logic              accept, clear, word_full;
    logic [DATA_W-1:0] packed_word;

    assign in_ready = (state == ST_ASSEMBLE);
    assign accept   = in_valid && in_ready;

    imem_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept),
        .data_byte (in_byte),
        .clear     (clear),
        .word      (packed_word),
        .word_full (word_full)
    );

    // Next state plus next values of every registered output.
    // wr_addr doubles as the word index: it is cleared on start and steps
    // once as each WRITE cycle ends, so after the last word it may read
    // DEPTH while wr_en is already low.
    always_comb begin
        state_d = state;
        count_d = count;
        addr_d  = wr_addr;
        data_d  = wr_data;
        err_d   = 1'b0;
        clear   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    count_d = ((word_count == '0) || (word_count > DEPTH_A))
                              ? DEPTH_A : word_count;
                    addr_d  = '0;
                    clear   = 1'b1;
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_ASSEMBLE: begin
                err_d = start;
                if (word_full) begin
                    data_d  = packed_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                err_d  = start;
                addr_d = wr_addr + 1'b1;
                if (wr_addr == count - 1'b1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ASSEMBLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_en_d = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        hold_d  = (state_d != ST_DONE);
    end

    // State, latched count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
            start_err <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            wr_addr   <= addr_d;
            wr_data   <= data_d;
            wr_en     <= wr_en_d;
            busy      <= busy_d;
            done      <= done_d;
            cpu_hold  <= hold_d;
            start_err <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed load sequence with random bytes and
// random in_valid gaps; expected writes are derived from the byte list.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  word_count = 8'd0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, busy, done, cpu_hold, start_err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int viol = 0;
    int serr = 0;

    logic [7:0]  aq[$];
    logic [31:0] dq[$];
    int          wcyc[$];
    int          acc_cyc[$];
    logic [7:0]  d[$];
    logic [7:0]  b[$];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .start_err  (start_err)
    );

    always #5 clk = ~clk;

    // Cycle counter: value N between the edges that bound cycle N.
    always @(posedge clk) cyc <= cyc + 1;

    // Write and start_err log, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            aq.push_back(wr_addr);
            dq.push_back(wr_data);
            wcyc.push_back(cyc);
            if (in_ready) viol++;
            if (wr_addr > 8'd63) viol++;
        end
        if (start_err) serr++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        aq.delete();
        dq.delete();
        wcyc.delete();
        acc_cyc.delete();
    endtask

    task automatic rand_bytes(input int n);
        b.delete();
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    // Reference: the first eff words of the byte list, big-endian, at 0..eff-1.
    task automatic check_writes(input string tag, input int wc, input logic [7:0] bytes[$]);
        int eff;
        logic [31:0] exp;
        eff = (wc == 0 || wc > 64) ? 64 : wc;
        chk({tag, "_nwrites"}, aq.size(), eff);
        for (int k = 0; k < eff && k < aq.size(); k++) begin
            exp = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
            chk({tag, "_addr"}, aq[k], k);
            chk({tag, "_data"}, dq[k], exp);
        end
    endtask

    task automatic pulse_start(input int wc);
        @(negedge clk);
        word_count = 8'(wc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer bytes until n are accepted (or abort_idx reached); optional
    // extra start pulse once start_idx bytes have been accepted.
    task automatic send(input logic [7:0] bytes[$], input int n, input bit gaps,
                        input int start_idx, input int abort_idx);
        int idx = 0;
        int guard = 0;
        bit sent = 1'b0;
        bit v;
        while (idx < n && idx != abort_idx && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (idx == start_idx && !sent) begin
                start = 1'b1;
                word_count = 8'd1;
                sent = 1'b1;
            end else begin
                start = 1'b0;
            end
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid = v;
            in_byte = bytes[idx];
            if (v && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        chk("send_progress", (idx == n || idx == abort_idx), 1);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(tag, done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hold"}, cpu_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_wren"}, wr_en, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, start_err, 0);
    endtask

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_nwrites", aq.size(), 0);
        chk("idle_hold", cpu_hold, 1);
        chk("idle_ready", in_ready, 0);

        // Two-word load, in_valid held high, with latency checks
        d = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        clear_log();
        pulse_start(2);
        send(d, 8, 1'b0, -1, -1);
        chk("lat_wren_n1", wr_en, 1);
        chk("lat_done_n1", done, 0);
        @(negedge clk);
        chk("lat_done_n2", done, 1);
        chk("lat_hold_n2", cpu_hold, 0);
        check_writes("w2", 2, d);
        if (wcyc.size() == 2 && acc_cyc.size() == 8) begin
            chk("lat_w0", wcyc[0], acc_cyc[3] + 1);
            chk("lat_w1", wcyc[1], acc_cyc[7] + 1);
        end else begin
            chk("lat_logsize", {wcyc.size(), acc_cyc.size()}, {32'd2, 32'd8});
        end
        repeat (5) @(negedge clk);
        chk("w2_no_extra", aq.size(), 2);

        // Same stream with random gaps, restarted from DONE
        clear_log();
        viol = 0;
        pulse_start(2);
        chk("restart_done_low", done, 0);
        chk("restart_hold_high", cpu_hold, 1);
        send(d, 8, 1'b1, -1, -1);
        wait_done("gap_done");
        check_writes("gap", 2, d);
        chk("gap_viol", viol, 0);

        // Count clamp: 0 and 200 both mean 64 words
        rand_bytes(256);
        clear_log();
        viol = 0;
        pulse_start(0);
        send(b, 256, 1'b0, -1, -1);
        wait_done("c0_done");
        check_writes("c0", 0, b);
        chk("c0_viol", viol, 0);
        repeat (3) @(negedge clk);
        chk("c0_no_extra", aq.size(), 64);

        rand_bytes(256);
        clear_log();
        viol = 0;
        pulse_start(200);
        send(b, 256, 1'b1, -1, -1);
        wait_done("c200_done");
        check_writes("c200", 200, b);
        if (aq.size() > 0) chk("c200_last", aq[aq.size()-1], 63);
        chk("c200_viol", viol, 0);

        // Start while busy: ignored, one start_err, original count kept
        rand_bytes(12);
        clear_log();
        serr = 0;
        pulse_start(3);
        send(b, 12, 1'b1, 2, -1);
        wait_done("busy_done");
        check_writes("busy", 3, b);
        chk("busy_serr", serr, 1);

        // Start from DONE with one word
        rand_bytes(4);
        clear_log();
        pulse_start(1);
        chk("one_hold", cpu_hold, 1);
        chk("one_done", done, 0);
        send(b, 4, 1'b0, -1, -1);
        chk("one_hold_writing", cpu_hold, 1);
        wait_done("one_done_end");
        check_writes("one", 1, b);
        chk("one_serr", serr, 1);

        // Reset mid-load after byte 3 of word 1
        rand_bytes(8);
        clear_log();
        pulse_start(2);
        send(b, 8, 1'b0, -1, 7);
        chk("mid_w0_written", aq.size(), 1);
        rst_n = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_nwrites", aq.size(), 0);

        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_log();
        pulse_start(1);
        send(d, 4, 1'b1, -1, -1);
        wait_done("dead_done");
        check_writes("dead", 1, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
